// File: rtl/host_wr_pacer_if.sv
`default_nettype none
//==============================================================================
// Module   : host_wr_pacer_if
// Brief    : Host bus plus register-write bus around host_wr_pacer.
// Revision : 1.0 - initial release
//==============================================================================
interface host_wr_pacer_if #(
  parameter int DATA_W = 8,
  parameter int BANK_W = 1
);
  logic              cs_n;
  logic              rd_n;
  logic              wr_n;
  logic [BANK_W:0]   address;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] status;
  logic              reg_wr_valid;
  logic              reg_wr_ready;
  logic [BANK_W-1:0] reg_wr_bank;
  logic [DATA_W-1:0] reg_wr_address;
  logic [DATA_W-1:0] reg_wr_data;

  modport master (
    output cs_n, rd_n, wr_n, address, din, status, reg_wr_ready,
    input  dout, reg_wr_valid, reg_wr_bank, reg_wr_address, reg_wr_data
  );

  modport slave (
    input  cs_n, rd_n, wr_n, address, din, status, reg_wr_ready,
    output dout, reg_wr_valid, reg_wr_bank, reg_wr_address, reg_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/host_wr_pacer.sv
`default_nettype none
//==============================================================================
// Module   : host_wr_pacer
// Brief    : Queues host address/data port writes and replays them as paced
//            register writes. HOST_WR_PACER_DROP_CNT_EN adds drop_count.
// Revision : 1.0 - initial release
//==============================================================================
module host_wr_pacer #(
  parameter int DATA_W  = 8,
  parameter int BANK_W  = 1,
  parameter int LGDEPTH = 6,
  parameter int MIN_GAP = 4
) (
  input  wire              clk,
  input  wire              reset,
  host_wr_pacer_if.slave   bus,
  output logic [LGDEPTH:0] fifo_level,
  output logic             overflow
`ifdef HOST_WR_PACER_DROP_CNT_EN
  ,
  output logic [15:0]      drop_count
`endif
);

  localparam int c_DEPTH   = 2 ** LGDEPTH;
  localparam int c_ENTRY_W = BANK_W + 1 + DATA_W;
  localparam int c_GAP_W   = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam logic [LGDEPTH:0]   c_FULL     = {1'b1, {LGDEPTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam state_t c_AFTER = (MIN_GAP == 0) ? S_IDLE : S_GAP;

  logic                 r_cs_p1_n;
  logic                 r_wr_p1_n;
  logic                 r_wr_p1_q;
  logic [BANK_W:0]      r_addr_p1;
  logic [DATA_W-1:0]    r_din_p1;
  logic [DATA_W-1:0]    r_status_p1;
  logic [DATA_W-1:0]    r_dout;
  logic                 w_wr_p1;
  logic                 w_push_req;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic [c_ENTRY_W-1:0] r_mem [c_DEPTH];
  logic [LGDEPTH-1:0]   r_wr_ptr;
  logic [LGDEPTH-1:0]   r_rd_ptr;
  logic [LGDEPTH:0]     r_level;
  logic                 r_overflow;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_ENTRY_W-1:0] r_entry;
  logic [BANK_W-1:0]    w_ent_bank;
  logic                 w_ent_is_data;
  logic [DATA_W-1:0]    w_ent_data;
  logic [BANK_W-1:0]    r_bank;
  logic [DATA_W-1:0]    r_reg_addr;
  logic [DATA_W-1:0]    r_wr_data;
  logic [c_GAP_W-1:0]   r_gap_cnt;
  logic                 w_unused_rd;

  // Reads have no side effects; the strobe is intentionally ignored.
  assign w_unused_rd = bus.rd_n;

  // Input stage. address_p1 resets to all-ones so dout stays all-ones
  // through the first cycle after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs_p1_n   <= 1'b1;
      r_wr_p1_n   <= 1'b1;
      r_wr_p1_q   <= 1'b0;
      r_addr_p1   <= '1;
      r_din_p1    <= '0;
      r_status_p1 <= '0;
      r_dout      <= '1;
    end else begin
      r_cs_p1_n   <= bus.cs_n;
      r_wr_p1_n   <= bus.wr_n;
      r_wr_p1_q   <= w_wr_p1;
      r_addr_p1   <= bus.address;
      r_din_p1    <= bus.din;
      r_status_p1 <= bus.status;
      r_dout      <= (r_addr_p1 == '0) ? r_status_p1 : '1;
    end
  end

  assign w_wr_p1    = !r_cs_p1_n && !r_wr_p1_n;
  assign w_push_req = w_wr_p1 && !r_wr_p1_q;
  assign w_full     = (r_level == c_FULL);
  assign w_empty    = (r_level == '0);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_addr_p1[BANK_W:1], r_addr_p1[0], r_din_p1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign w_ent_bank    = r_entry[c_ENTRY_W-1 -: BANK_W];
  assign w_ent_is_data = r_entry[DATA_W];
  assign w_ent_data    = r_entry[DATA_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC:  w_state_nxt = w_ent_is_data ? S_WAIT : c_AFTER;
      S_WAIT:  if (bus.reg_wr_ready) w_state_nxt = c_AFTER;
      S_GAP:   if (r_gap_cnt == c_GAP_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bank/address latch persists across data entries until the next address entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_entry    <= '0;
      r_bank     <= '0;
      r_reg_addr <= '0;
      r_wr_data  <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (w_pop) r_entry <= r_mem[r_rd_ptr];
      if (r_state == S_EXEC) begin
        if (w_ent_is_data) begin
          r_wr_data <= w_ent_data;
        end else begin
          r_bank     <= w_ent_bank;
          r_reg_addr <= w_ent_data;
        end
      end
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
    end
  end

  assign bus.reg_wr_valid   = (r_state == S_WAIT);
  assign bus.reg_wr_bank    = r_bank;
  assign bus.reg_wr_address = r_reg_addr;
  assign bus.reg_wr_data    = r_wr_data;
  assign bus.dout           = r_dout;
  assign fifo_level         = r_level;
  assign overflow           = r_overflow;

`ifdef HOST_WR_PACER_DROP_CNT_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_host_wr_pacer.sv
`default_nettype none
//==============================================================================
// Module   : tb_host_wr_pacer
// Brief    : Directed, table-driven bench for host_wr_pacer.
// Revision : 1.0 - initial release
//==============================================================================
module tb_host_wr_pacer;
  localparam int DATA_W  = 8;
  localparam int BANK_W  = 1;
  localparam int LGDEPTH = 6;
  localparam int MIN_GAP = 4;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef struct {
    logic [BANK_W:0]   port;
    logic [DATA_W-1:0] din;
    int                exp_cnt;
    logic [BANK_W-1:0] exp_bank;
    logic [DATA_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
  } wr_vec_t;

  typedef struct {
    logic [DATA_W-1:0] status;
    logic [BANK_W:0]   port;
    logic [DATA_W-1:0] exp_dout;
  } rd_vec_t;

  logic             clk;
  logic             reset;
  logic [LGDEPTH:0] fifo_level;
  logic             overflow;
`ifdef HOST_WR_PACER_DROP_CNT_EN
  logic [15:0]      drop_count;
`endif

  host_wr_pacer_if #(.DATA_W(DATA_W), .BANK_W(BANK_W)) bus ();

  host_wr_pacer #(
    .DATA_W (DATA_W),
    .BANK_W (BANK_W),
    .LGDEPTH(LGDEPTH),
    .MIN_GAP(MIN_GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fifo_level(fifo_level),
    .overflow  (overflow)
`ifdef HOST_WR_PACER_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   valid_cycles = 0;
  req_t q_req[$];
  int   q_cyc[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Completed handshakes are logged mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.reg_wr_valid === 1'b1) begin
      valid_cycles++;
      if (bus.reg_wr_ready === 1'b1) begin
        q_req.push_back({bus.reg_wr_bank, bus.reg_wr_address, bus.reg_wr_data});
        q_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [BANK_W:0] a, input logic [DATA_W-1:0] d, input int len);
    bus.address = a;
    bus.din     = d;
    bus.cs_n    = 1'b0;
    bus.wr_n    = 1'b0;
    tick(len);
    bus.cs_n    = 1'b1;
    bus.wr_n    = 1'b1;
    tick(1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (bus.reg_wr_valid !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, bus.reg_wr_valid, 1);
  endtask

  wr_vec_t wv[8];
  rd_vec_t rv[5];
  int      n0;
  int      lat;
  int      vlen;
  int      found;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    wv[0] = '{2'b00, 8'hB0, 0, 1'b0, 8'h00, 8'h00};
    wv[1] = '{2'b01, 8'h2A, 1, 1'b0, 8'hB0, 8'h2A};
    wv[2] = '{2'b10, 8'h05, 0, 1'b0, 8'h00, 8'h00};
    wv[3] = '{2'b11, 8'h11, 1, 1'b1, 8'h05, 8'h11};
    wv[4] = '{2'b01, 8'h77, 1, 1'b1, 8'h05, 8'h77};
    wv[5] = '{2'b00, 8'h3C, 0, 1'b0, 8'h00, 8'h00};
    wv[6] = '{2'b00, 8'h4D, 0, 1'b0, 8'h00, 8'h00};
    wv[7] = '{2'b11, 8'h99, 1, 1'b0, 8'h4D, 8'h99};
    rv[0] = '{8'h60, 2'b00, 8'h60};
    rv[1] = '{8'h60, 2'b10, 8'hFF};
    rv[2] = '{8'h60, 2'b01, 8'hFF};
    rv[3] = '{8'hA5, 2'b00, 8'hA5};
    rv[4] = '{8'h60, 2'b11, 8'hFF};

    reset            = 1'b1;
    bus.cs_n         = 1'b1;
    bus.rd_n         = 1'b1;
    bus.wr_n         = 1'b1;
    bus.address      = '0;
    bus.din          = '0;
    bus.status       = '0;
    bus.reg_wr_ready = 1'b1;
    #1;
    check("rst_dout", bus.dout, 8'hFF);
    check("rst_valid", bus.reg_wr_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_payload", {bus.reg_wr_bank, bus.reg_wr_address, bus.reg_wr_data}, 0);
`ifdef HOST_WR_PACER_DROP_CNT_EN
    check("rst_drop_count", drop_count, 0);
`endif
    tick(3);
    reset = 1'b0;
    tick(2);

    // Latency and pulse width: data entry before any address entry.
    bus.address = 2'b01;
    bus.din     = 8'h5A;
    bus.cs_n    = 1'b0;
    bus.wr_n    = 1'b0;
    lat  = 0;
    vlen = 0;
    for (int n = 1; n <= 10; n++) begin
      tick(1);
      if (n == 1) begin
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
      end
      if (bus.reg_wr_valid === 1'b1 && lat == 0) lat = n;
      else if (lat != 0 && vlen == 0 && bus.reg_wr_valid !== 1'b1) vlen = n - lat;
    end
    check("latency", lat, 4);
    check("valid_width", vlen, 1);
    tick(6);
    check("first_req_count", q_req.size(), 1);
    check("first_req_payload", q_req[0], {1'b0, 8'h00, 8'h5A});

    for (int i = 0; i < 8; i++) begin
      n0 = q_req.size();
      host_write(wv[i].port, wv[i].din, 1);
      tick(14);
      check($sformatf("wv%0d_count", i), q_req.size() - n0, wv[i].exp_cnt);
      if (wv[i].exp_cnt == 1 && q_req.size() > n0) begin
        check($sformatf("wv%0d_bank", i), q_req[n0].bank, wv[i].exp_bank);
        check($sformatf("wv%0d_addr", i), q_req[n0].addr, wv[i].exp_addr);
        check($sformatf("wv%0d_data", i), q_req[n0].data, wv[i].exp_data);
      end
    end
    check("valid_cycles_eq_reqs", valid_cycles, q_req.size());

    // Back-to-back data entries must be separated by the minimum gap.
    n0 = q_req.size();
    host_write(2'b10, 8'h05, 1);
    host_write(2'b11, 8'h11, 1);
    host_write(2'b11, 8'h22, 1);
    tick(30);
    check("gap_count", q_req.size() - n0, 2);
    if (q_req.size() >= n0 + 2) begin
      check("gap_req0", q_req[n0], {1'b1, 8'h05, 8'h11});
      check("gap_req1", q_req[n0+1], {1'b1, 8'h05, 8'h22});
      check("gap_idle_ge_min", (q_cyc[n0+1] - q_cyc[n0] - 1) >= MIN_GAP, 1);
    end

    // Long strobe yields one entry only.
    n0 = q_req.size();
    host_write(2'b01, 8'h3E, 10);
    tick(14);
    check("long_strobe_count", q_req.size() - n0, 1);
    check("long_strobe_level", fifo_level, 0);

    // Downstream stall: request held stable.
    bus.reg_wr_ready = 1'b0;
    n0 = q_req.size();
    host_write(2'b00, 8'h44, 1);
    host_write(2'b01, 8'h55, 1);
    wait_valid("stall_valid", 30);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_hold%0d", k),
            {bus.reg_wr_valid, bus.reg_wr_bank, bus.reg_wr_address, bus.reg_wr_data},
            {1'b1, 1'b0, 8'h44, 8'h55});
      tick(1);
    end
    bus.reg_wr_ready = 1'b1;
    tick(1);
    check("stall_release_valid", bus.reg_wr_valid, 0);
    check("stall_count", q_req.size() - n0, 1);
    tick(12);

    // Overflow: one entry parked in the stalled request, 64 queued, 65th dropped.
    bus.reg_wr_ready = 1'b0;
    n0 = q_req.size();
    host_write(2'b01, 8'hC0, 1);
    wait_valid("ovf_park_valid", 30);
    check("ovf_park_level", fifo_level, 0);
    for (int i = 0; i < 64; i++) host_write(2'b01, 8'(i), 1);
    tick(2);
    check("ovf_level_full", fifo_level, 64);
    check("ovf_not_yet", overflow, 0);
    host_write(2'b01, 8'hEE, 1);
    tick(2);
    check("ovf_level_after_drop", fifo_level, 64);
    check("ovf_sticky_set", overflow, 1);
`ifdef HOST_WR_PACER_DROP_CNT_EN
    check("ovf_drop_count", drop_count, 1);
`endif
    bus.reg_wr_ready = 1'b1;
    for (int k = 0; k < 1500 && (q_req.size() - n0) < 65; k++) tick(1);
    tick(20);
    check("ovf_drain_count", q_req.size() - n0, 65);
    found = 0;
    for (int k = n0; k < q_req.size(); k++) if (q_req[k].data == 8'hEE) found++;
    check("ovf_dropped_never_emitted", found, 0);
    if (q_req.size() >= n0 + 65) check("ovf_last_data", q_req[n0+64].data, 8'h3F);
    check("ovf_still_sticky", overflow, 1);
    check("ovf_level_drained", fifo_level, 0);

    // Status readback.
    bus.cs_n = 1'b0;
    bus.rd_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.status  = rv[i].status;
      bus.address = rv[i].port;
      tick(2);
      check($sformatf("rv%0d_dout", i), bus.dout, rv[i].exp_dout);
    end
    bus.cs_n = 1'b1;
    bus.rd_n = 1'b1;
    tick(2);

    // Reset while a request is waiting for ready.
    bus.reg_wr_ready = 1'b0;
    host_write(2'b10, 8'h12, 1);
    host_write(2'b11, 8'h34, 1);
    wait_valid("rst_wait_valid", 30);
    host_write(2'b01, 8'hA1, 1);
    host_write(2'b01, 8'hA2, 1);
    host_write(2'b01, 8'hA3, 1);
    check("pre_rst_level", fifo_level, 3);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", bus.reg_wr_valid, 0);
    check("async_rst_level", fifo_level, 0);
    check("async_rst_overflow", overflow, 0);
    check("async_rst_dout", bus.dout, 8'hFF);
`ifdef HOST_WR_PACER_DROP_CNT_EN
    check("async_rst_drop_count", drop_count, 0);
`endif
    tick(2);
    reset = 1'b0;
    bus.reg_wr_ready = 1'b1;
    n0 = q_req.size();
    tick(1);
    check("post_rst_dout", bus.dout, 8'hFF);
    tick(20);
    check("post_rst_no_req", q_req.size() - n0, 0);

    // Latch returns to bank 0 / address 0 after reset.
    host_write(2'b01, 8'h66, 1);
    tick(14);
    check("recover_count", q_req.size() - n0, 1);
    if (q_req.size() > n0) check("recover_payload", q_req[n0], {1'b0, 8'h00, 8'h66});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
